// File: rtl/ddr_arb_pkg.sv
// Shared constants for the DDR address arbiter: command codes,
// FSM state encodings and the width helper.
package ddr_arb_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam logic [0:0] INIT_WAIT = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r++;
            t = t >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_ring_ptr.sv
// Ring-buffer burst pointer with power-of-two wrap; the address
// output is the DDR column address of the current slot.
module ddr_ring_ptr
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int ADDR_INC   = 4,
    parameter int BUF_BASE   = 0,
    parameter int BUF_DEPTH  = 1024
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  i_adv,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam int PW = clog2(BUF_DEPTH);

    logic [PW-1:0] r_ptr;

    // Pointer width equals log2(depth), so the increment wraps by itself.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign o_addr = ADDR_WIDTH'(BUF_BASE)
                  + ADDR_WIDTH'(r_ptr) * ADDR_WIDTH'(ADDR_INC);

endmodule

// File: rtl/ddr_addr_arb.sv
// Arbitrates write/read bursts onto the MIG app_af port and tracks
// how many written bursts are waiting in the DDR ring buffer.
module ddr_addr_arb
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 31,
    parameter int ADDR_INC   = 4,
    parameter int BUF_BASE   = 0,
    parameter int BUF_DEPTH  = 1024,
    parameter int PEND_WIDTH = 3
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      phy_init_done,
    input  logic                      wr_addr_en,
    input  logic                      rd_addr_en,
    input  logic                      app_af_afull,
    output logic                      app_af_wren,
    output logic [2:0]                app_af_cmd,
    output logic [ADDR_WIDTH-1:0]     app_af_addr,
    output logic                      rd_en,
    output logic                      addr_confilct,
    output logic                      buf_full,
    output logic [clog2(BUF_DEPTH):0] fill_level,
    output logic                      ovf_err
);

    localparam int FW = clog2(BUF_DEPTH) + 1;
    localparam logic [FW-1:0]         FULL     = FW'(BUF_DEPTH);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [0:0]            r_state;
    logic [PEND_WIDTH-1:0] r_wr_pend;
    logic [PEND_WIDTH-1:0] r_rd_pend;
    logic [FW-1:0]         r_fill;
    logic                  r_prio_rd;
    logic                  r_ovf;

    logic                  w_run;
    logic                  w_wr_elig;
    logic                  w_rd_elig;
    logic                  w_wr_issue;
    logic                  w_rd_issue;
    logic                  w_wr_drop;
    logic                  w_rd_drop;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    function automatic logic [PEND_WIDTH-1:0] next_pend(
        input logic [PEND_WIDTH-1:0] pend,
        input logic                  req,
        input logic                  iss
    );
        if (req && !iss && pend != PEND_MAX) begin
            return pend + PEND_WIDTH'(1);
        end else if (iss && !req) begin
            return pend - PEND_WIDTH'(1);
        end
        return pend;
    endfunction

    assign w_run      = (r_state == RUN) && phy_init_done && !app_af_afull;
    assign w_wr_elig  = w_run && (r_wr_pend != '0) && (r_fill != FULL);
    assign w_rd_elig  = w_run && (r_rd_pend != '0) && (r_fill != '0);
    assign w_wr_issue = w_wr_elig && !(w_rd_elig && r_prio_rd);
    assign w_rd_issue = w_rd_elig && !w_wr_issue;
    assign w_wr_drop  = wr_addr_en && !w_wr_issue && (r_wr_pend == PEND_MAX);
    assign w_rd_drop  = rd_addr_en && !w_rd_issue && (r_rd_pend == PEND_MAX);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= INIT_WAIT;
        end else begin
            case (r_state)
                INIT_WAIT: if (phy_init_done)  r_state <= RUN;
                RUN:       if (!phy_init_done) r_state <= INIT_WAIT;
                default:   r_state <= INIT_WAIT;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wr_pend   <= '0;
            r_rd_pend   <= '0;
            r_fill      <= '0;
            r_prio_rd   <= 1'b0;
            r_ovf       <= 1'b0;
            app_af_wren <= 1'b0;
            app_af_cmd  <= CMD_WRITE;
            app_af_addr <= ADDR_WIDTH'(BUF_BASE);
        end else begin
            r_wr_pend   <= next_pend(r_wr_pend, wr_addr_en, w_wr_issue);
            r_rd_pend   <= next_pend(r_rd_pend, rd_addr_en, w_rd_issue);
            r_ovf       <= r_ovf | w_wr_drop | w_rd_drop;
            app_af_wren <= w_wr_issue | w_rd_issue;
            if (w_wr_issue) begin
                app_af_cmd  <= CMD_WRITE;
                app_af_addr <= w_wr_addr;
                r_fill      <= r_fill + FW'(1);
                r_prio_rd   <= 1'b1;
            end else if (w_rd_issue) begin
                app_af_cmd  <= CMD_READ;
                app_af_addr <= w_rd_addr;
                r_fill      <= r_fill - FW'(1);
                r_prio_rd   <= 1'b0;
            end
        end
    end

    ddr_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_INC   (ADDR_INC),
        .BUF_BASE   (BUF_BASE),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_wr_ptr (
        .sys_clk (sys_clk),
        .reset   (reset),
        .i_adv   (w_wr_issue),
        .o_addr  (w_wr_addr)
    );

    ddr_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_INC   (ADDR_INC),
        .BUF_BASE   (BUF_BASE),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_rd_ptr (
        .sys_clk (sys_clk),
        .reset   (reset),
        .i_adv   (w_rd_issue),
        .o_addr  (w_rd_addr)
    );

    assign fill_level    = r_fill;
    assign rd_en         = (r_fill != '0);
    assign addr_confilct = (r_fill == '0);
    assign buf_full      = (r_fill == FULL);
    assign ovf_err       = r_ovf;

endmodule

// File: tb/tb_ddr_addr_arb.sv
// Randomized and directed bench for ddr_addr_arb against a
// behavioural model of the ring buffer and request counts.
module tb_ddr_addr_arb;

    localparam int AW    = 31;
    localparam int INC   = 4;
    localparam int BASE  = 0;
    localparam int DEPTH = 4;
    localparam int PENDW = 3;
    localparam int PMAX  = (1 << PENDW) - 1;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          phy_init_done = 1'b0;
    logic          wr_addr_en = 1'b0;
    logic          rd_addr_en = 1'b0;
    logic          app_af_afull = 1'b0;
    logic          app_af_wren;
    logic [2:0]    app_af_cmd;
    logic [AW-1:0] app_af_addr;
    logic          rd_en;
    logic          addr_confilct;
    logic          buf_full;
    logic [2:0]    fill_level;
    logic          ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_run, m_wp, m_rp, m_fill, m_wptr, m_rptr, m_prio_rd, m_ovf;
    int e_wren, e_cmd, e_addr;

    always #5 sys_clk = ~sys_clk;

    ddr_addr_arb #(
        .ADDR_WIDTH (AW),
        .ADDR_INC   (INC),
        .BUF_BASE   (BASE),
        .BUF_DEPTH  (DEPTH),
        .PEND_WIDTH (PENDW)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .phy_init_done (phy_init_done),
        .wr_addr_en    (wr_addr_en),
        .rd_addr_en    (rd_addr_en),
        .app_af_afull  (app_af_afull),
        .app_af_wren   (app_af_wren),
        .app_af_cmd    (app_af_cmd),
        .app_af_addr   (app_af_addr),
        .rd_en         (rd_en),
        .addr_confilct (addr_confilct),
        .buf_full      (buf_full),
        .fill_level    (fill_level),
        .ovf_err       (ovf_err)
    );

    task automatic chk(input string tag, input longint unsigned got,
                       input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference: who may issue, who wins, what moves.
    task automatic model_step();
        bit can, we, re, dw, dr;
        if (reset) begin
            m_run = 0; m_wp = 0; m_rp = 0; m_fill = 0;
            m_wptr = 0; m_rptr = 0; m_prio_rd = 0; m_ovf = 0;
            e_wren = 0; e_cmd = 0; e_addr = BASE;
            return;
        end
        can = (m_run != 0) && phy_init_done && !app_af_afull;
        we  = can && m_wp > 0 && m_fill < DEPTH;
        re  = can && m_rp > 0 && m_fill > 0;
        dw  = we && !(re && m_prio_rd != 0);
        dr  = re && !dw;
        e_wren = (dw || dr) ? 1 : 0;
        if (dw) begin
            e_cmd = 0;
            e_addr = BASE + m_wptr * INC;
            m_wptr = (m_wptr + 1) % DEPTH;
            m_fill++;
            m_prio_rd = 1;
        end
        if (dr) begin
            e_cmd = 1;
            e_addr = BASE + m_rptr * INC;
            m_rptr = (m_rptr + 1) % DEPTH;
            m_fill--;
            m_prio_rd = 0;
        end
        if (wr_addr_en && !dw) begin
            if (m_wp == PMAX) m_ovf = 1;
            else m_wp++;
        end else if (!wr_addr_en && dw) begin
            m_wp--;
        end
        if (rd_addr_en && !dr) begin
            if (m_rp == PMAX) m_ovf = 1;
            else m_rp++;
        end else if (!rd_addr_en && dr) begin
            m_rp--;
        end
        m_run = phy_init_done ? 1 : 0;
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        #1;
        chk("wren", app_af_wren, e_wren);
        chk("cmd", app_af_cmd, e_cmd);
        chk("addr", app_af_addr, e_addr);
        chk("fill", fill_level, m_fill);
        chk("rd_en", rd_en, m_fill > 0);
        chk("conflict", addr_confilct, m_fill == 0);
        chk("full", buf_full, m_fill == DEPTH);
        chk("ovf", ovf_err, m_ovf);
    endtask

    task automatic drive(input logic r, input logic p, input logic w,
                         input logic rd, input logic af);
        reset = r;
        phy_init_done = p;
        wr_addr_en = w;
        rd_addr_en = rd;
        app_af_afull = af;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        idle(2);
        chk("rst_wren", app_af_wren, 0);
        chk("rst_addr", app_af_addr, BASE);
        chk("rst_confl", addr_confilct, 1);
        chk("rst_fill", fill_level, 0);

        // init gating
        drive(0, 0, 1, 0, 0);
        idle(3);
        drive(0, 0, 0, 0, 0);
        idle(2);
        chk("init_nowren", app_af_wren, 0);
        drive(0, 1, 0, 0, 0);
        idle(2);
        chk("init_w0", app_af_addr, 0);
        idle(1);
        chk("init_w1", app_af_addr, 4);
        idle(1);
        chk("init_w2", app_af_addr, 8);
        idle(2);
        chk("init_fill", fill_level, 3);

        // read on empty buffer
        drive(1, 1, 0, 0, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        idle(2);
        drive(0, 1, 0, 1, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        idle(3);
        chk("empty_confl", addr_confilct, 1);
        chk("empty_nowren", app_af_wren, 0);
        drive(0, 1, 1, 0, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        idle(4);
        chk("empty_fill", fill_level, 0);

        // alternation: fill=1, last issue a read
        drive(0, 1, 1, 0, 0);
        idle(2);
        drive(0, 1, 0, 0, 0);
        idle(3);
        drive(0, 1, 0, 1, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        idle(3);
        chk("alt_fill", fill_level, 1);
        drive(0, 1, 1, 1, 1);
        idle(2);
        drive(0, 1, 0, 0, 1);
        idle(1);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("alt_wren", app_af_wren, 1);
            chk("alt_cmd", app_af_cmd, i % 2);
        end
        idle(2);

        // backpressure, full buffer and wrap
        drive(1, 1, 0, 0, 0);
        idle(1);
        drive(0, 1, 1, 0, 1);
        idle(5);
        chk("af_nowren", app_af_wren, 0);
        drive(0, 1, 0, 0, 0);
        idle(7);
        chk("full_flag", buf_full, 1);
        chk("full_fill", fill_level, 4);
        chk("full_stall", app_af_wren, 0);
        drive(0, 1, 0, 1, 0);
        idle(1);
        drive(0, 1, 0, 0, 0);
        idle(1);
        chk("wrap_rcmd", app_af_cmd, 1);
        idle(1);
        chk("wrap_wren", app_af_wren, 1);
        chk("wrap_wcmd", app_af_cmd, 0);
        chk("wrap_addr", app_af_addr, 0);
        idle(2);

        // pending overflow
        drive(1, 1, 0, 0, 0);
        idle(1);
        drive(0, 1, 1, 0, 1);
        idle(8);
        drive(0, 1, 0, 0, 1);
        idle(1);
        chk("ovf_set", ovf_err, 1);
        drive(0, 1, 0, 0, 0);
        idle(10);
        chk("ovf_sticky", ovf_err, 1);

        // reset with requests pending
        drive(1, 1, 0, 0, 0);
        idle(1);
        drive(0, 1, 1, 0, 1);
        idle(2);
        drive(1, 1, 0, 0, 1);
        idle(1);
        chk("mid_ovf", ovf_err, 0);
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("mid_nowren", app_af_wren, 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) >= 3,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 20);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
